// File: rtl/trng_sequencer.sv
// trng_sequencer: control and post-processing for the ring-oscillator TRNG.
// Enables the oscillator, waits out a warm-up interval, samples the raw bit
// on each synchronised rising edge of the slow oscillator, applies a
// repetition-count health test and optional von Neumann debiasing, and packs
// the surviving bits MSB-first into words offered on a valid/ready port.
module trng_sequencer #(
    parameter int WARMUP_CYCLES = 1024,
    parameter int REP_LIMIT     = 32,
    parameter int OUT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 debias_en,
    input  logic [1:0]           cfg_div_sel,
    input  logic [1:0]           cfg_fb_sel,
    input  logic                 slow_osc,
    input  logic                 raw_bit,
    output logic                 ro_enable,
    output logic [1:0]           div_sel,
    output logic [1:0]           fb_sel,
    output logic [OUT_WIDTH-1:0] rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 health_fail,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    // Counter widths; the warm-up counter only ever has to reach WARMUP_CYCLES-1.
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int CNT_W  = $clog2(OUT_WIDTH + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(OUT_WIDTH - 1);
    localparam logic [7:0]        RUN_LIMIT = 8'(REP_LIMIT);

    state_t               state;

    // Synchroniser stages; osc_s3 is only an edge-detect delay of osc_s2.
    logic                 osc_s1;
    logic                 osc_s2;
    logic                 osc_s3;
    logic                 raw_s1;
    logic                 raw_s2;

    // Configuration captured when a run begins.
    logic                 debias_q;

    // Packing, pairing and health-test state.
    logic [OUT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 pair_full;
    logic                 pair_first;
    logic [7:0]           run_cnt;
    logic                 prev_sample;
    logic [WARM_W-1:0]    warm_cnt;

    // Combinational helpers evaluated every cycle, used only on a strobe.
    logic                 sample_stb;
    logic                 sample;
    logic [7:0]           run_next;
    logic                 health_hit;
    logic                 emit_valid;
    logic                 emit_bit;
    logic [OUT_WIDTH-1:0] word_next;
    logic                 word_done;

    assign state_o = state;

    // Bring slow_osc and raw_bit into the clk domain; both paths have equal
    // latency so the raw bit seen with the strobe matches the oscillator edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
            raw_s1 <= 1'b0;
            raw_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value, forming a real shift chain.
            osc_s1 <= slow_osc;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
            raw_s1 <= raw_bit;
            raw_s2 <= raw_s1;
        end
    end

    assign sample_stb = osc_s2 & ~osc_s3;
    assign sample     = raw_s2;

    // Repetition-count health test: length of the current run including this sample.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        run_next   = 8'd1;
        health_hit = 1'b0;
        if ((run_cnt != 8'd0) && (sample == prev_sample)) begin
            run_next = run_cnt + 8'd1;
        end
        health_hit = (run_next == RUN_LIMIT);
    end

    // Debias selection: raw pass-through, or first bit of an unequal pair.
    always_comb begin
        emit_valid = 1'b0;
        emit_bit   = 1'b0;
        if (debias_q) begin
            if (pair_full && (sample != pair_first)) begin
                emit_valid = 1'b1;
                emit_bit   = pair_first;
            end
        end else begin
            emit_valid = 1'b1;
            emit_bit   = sample;
        end
    end

    // Word packer: the first emitted bit migrates up into the MSB.
    always_comb begin
        word_next = {shreg[OUT_WIDTH-2:0], emit_bit};
        word_done = (bit_cnt == BIT_LAST);
    end

    // Main sequencer: state, configuration registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ro_enable   <= 1'b0;
            div_sel     <= 2'd0;
            fb_sel      <= 2'd0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
            debias_q    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            pair_full   <= 1'b0;
            pair_first  <= 1'b0;
            run_cnt     <= 8'd0;
            prev_sample <= 1'b0;
            warm_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ro_enable <= 1'b0;
                    if (start) begin
                        div_sel   <= cfg_div_sel;
                        fb_sel    <= cfg_fb_sel;
                        debias_q  <= debias_en;
                        ro_enable <= 1'b1;
                        warm_cnt  <= '0;
                        run_cnt   <= 8'd0;
                        state     <= WARMUP;
                    end
                end

                WARMUP: begin
                    // Strobes are ignored while the oscillator settles.
                    if (!start) begin
                        ro_enable <= 1'b0;
                        state     <= IDLE;
                    end else if (warm_cnt == WARM_LAST) begin
                        shreg     <= '0;
                        bit_cnt   <= '0;
                        pair_full <= 1'b0;
                        state     <= COLLECT;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end

                COLLECT: begin
                    if (!start) begin
                        // Abandon the partial word so a restart begins clean.
                        ro_enable <= 1'b0;
                        shreg     <= '0;
                        bit_cnt   <= '0;
                        pair_full <= 1'b0;
                        state     <= IDLE;
                    end else if (sample_stb) begin
                        run_cnt     <= run_next;
                        prev_sample <= sample;
                        if (health_hit) begin
                            // A failure outranks a word completing on the same strobe.
                            ro_enable   <= 1'b0;
                            rnd_valid   <= 1'b0;
                            health_fail <= 1'b1;
                            state       <= FAULT;
                        end else begin
                            if (debias_q) begin
                                if (!pair_full) begin
                                    pair_first <= sample;
                                end
                                pair_full <= ~pair_full;
                            end
                            if (emit_valid) begin
                                shreg   <= word_next;
                                bit_cnt <= bit_cnt + 1'b1;
                                if (word_done) begin
                                    rnd_data  <= word_next;
                                    rnd_valid <= 1'b1;
                                    state     <= HOLD;
                                end
                            end
                        end
                    end
                end

                HOLD: begin
                    // The health test keeps watching the source while the word waits.
                    if (sample_stb) begin
                        run_cnt     <= run_next;
                        prev_sample <= sample;
                    end
                    if (sample_stb && health_hit) begin
                        ro_enable   <= 1'b0;
                        rnd_valid   <= 1'b0;
                        health_fail <= 1'b1;
                        state       <= FAULT;
                    end else if (rnd_ready) begin
                        rnd_valid <= 1'b0;
                        bit_cnt   <= '0;
                        if (start) begin
                            pair_full <= 1'b0;
                            state     <= COLLECT;
                        end else begin
                            ro_enable <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end

                FAULT: begin
                    // Terminal until reset; start has no effect here.
                    ro_enable   <= 1'b0;
                    rnd_valid   <= 1'b0;
                    health_fail <= 1'b1;
                end

                default: begin
                    ro_enable <= 1'b0;
                    rnd_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_sequencer.sv
// tb_trng_sequencer: directed bench for trng_sequencer. A main instance
// (REP_LIMIT 32) covers warm-up, packing, debiasing, hold and abort; a second
// instance (REP_LIMIT 4) covers the health-test fault paths.
module tb_trng_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         start_h;
    logic         debias_en;
    logic [1:0]   cfg_div_sel;
    logic [1:0]   cfg_fb_sel;
    logic         slow_osc;
    logic         raw_bit;
    logic         rnd_ready;

    logic         ro_enable;
    logic [1:0]   div_sel;
    logic [1:0]   fb_sel;
    logic [W-1:0] rnd_data;
    logic         rnd_valid;
    logic         health_fail;
    logic [2:0]   state_o;

    logic         ro_enable_h;
    logic [1:0]   div_sel_h;
    logic [1:0]   fb_sel_h;
    logic [W-1:0] rnd_data_h;
    logic         rnd_valid_h;
    logic         health_fail_h;
    logic [2:0]   state_h;

    int n_checks = 0;
    int n_pass   = 0;

    trng_sequencer #(.WARMUP_CYCLES(8), .REP_LIMIT(32), .OUT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .debias_en(debias_en),
        .cfg_div_sel(cfg_div_sel), .cfg_fb_sel(cfg_fb_sel),
        .slow_osc(slow_osc), .raw_bit(raw_bit),
        .ro_enable(ro_enable), .div_sel(div_sel), .fb_sel(fb_sel),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail), .state_o(state_o)
    );

    trng_sequencer #(.WARMUP_CYCLES(8), .REP_LIMIT(4), .OUT_WIDTH(W)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(start_h), .debias_en(debias_en),
        .cfg_div_sel(cfg_div_sel), .cfg_fb_sel(cfg_fb_sel),
        .slow_osc(slow_osc), .raw_bit(raw_bit),
        .ro_enable(ro_enable_h), .div_sel(div_sel_h), .fb_sel(fb_sel_h),
        .rnd_data(rnd_data_h), .rnd_valid(rnd_valid_h), .rnd_ready(rnd_ready),
        .health_fail(health_fail_h), .state_o(state_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       debias;
        int         n;        // number of raw samples
        logic [31:0] smp;     // samples, first one in bit n-1
        logic [7:0] word;     // expected packed word
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One slow-oscillator period of 8 clk with raw_bit held at b.
    task automatic apply_sample(input logic b);
        raw_bit  = b;
        slow_osc = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        slow_osc = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            apply_sample(bits[i]);
        end
    endtask

    // Bounded wait for a state on either instance; a timeout shows as a failed check.
    task automatic wait_state(input string name, input bit use_h, input logic [2:0] want);
        for (int i = 0; i < 40; i++) begin
            if ((use_h ? state_h : state_o) == want) break;
            @(posedge clk);
            #1;
        end
        check(name, use_h ? state_h : state_o, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"deb_55",   1'b1, 20, 32'h0007_8666, 8'h55};
        vecs[1] = '{"deb_f0",   1'b1, 16, 32'h0000_AA55, 8'hF0};
        vecs[2] = '{"raw_c3",   1'b0,  8, 32'h0000_00C3, 8'hC3};
        vecs[3] = '{"raw_0f",   1'b0,  8, 32'h0000_000F, 8'h0F};

        // Reset with random inputs.
        rst_n       = 1'b0;
        start       = 1'($urandom);
        start_h     = 1'($urandom);
        debias_en   = 1'($urandom);
        cfg_div_sel = 2'($urandom);
        cfg_fb_sel  = 2'($urandom);
        slow_osc    = 1'($urandom);
        raw_bit     = 1'($urandom);
        rnd_ready   = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  state_o, 3'd0);
        check("rst_ro",     ro_enable, 1'b0);
        check("rst_div",    div_sel, 2'd0);
        check("rst_fb",     fb_sel, 2'd0);
        check("rst_data",   rnd_data, 8'h00);
        check("rst_valid",  rnd_valid, 1'b0);
        check("rst_health", health_fail, 1'b0);
        check("rst_state_h", state_h, 3'd0);

        start     = 1'b0;
        start_h   = 1'b0;
        debias_en = 1'b0;
        slow_osc  = 1'b0;
        raw_bit   = 1'b0;
        rnd_ready = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Warm-up: config latched one cycle after start; a strobe during warm-up is ignored.
        cfg_div_sel = 2'd2;
        cfg_fb_sel  = 2'd1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        check("wu_ro",    ro_enable, 1'b1);
        check("wu_div",   div_sel, 2'd2);
        check("wu_fb",    fb_sel, 2'd1);
        check("wu_state", state_o, 3'd1);
        cfg_div_sel = 2'd3;
        cfg_fb_sel  = 2'd3;
        slow_osc    = 1'b1;
        raw_bit     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        slow_osc = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wu_still_warm", state_o, 3'd1);
        @(posedge clk);
        #1;
        check("wu_collect", state_o, 3'd2);
        check("wu_div_hold", div_sel, 2'd2);

        // Debias off, 1,0,1,1,0,0,1,0 -> 8'hB2, held while ready is low.
        apply_bits(32'h59, 7);
        check("b2_not_yet", rnd_valid, 1'b0);
        apply_sample(1'b0);
        check("b2_valid", rnd_valid, 1'b1);
        check("b2_data",  rnd_data, 8'hB2);
        check("b2_hold",  state_o, 3'd3);
        for (int i = 0; i < 3; i++) begin
            apply_sample(1'(i % 2 == 0));
            check("b2_hold_valid", rnd_valid, 1'b1);
            check("b2_hold_data",  rnd_data, 8'hB2);
        end
        rnd_ready = 1'b1;
        @(posedge clk);
        #1;
        rnd_ready = 1'b0;
        check("b2_accept_valid", rnd_valid, 1'b0);
        check("b2_accept_state", state_o, 3'd2);

        // Next word from fresh samples only.
        apply_bits(32'h5A, 8);
        check("5a_valid", rnd_valid, 1'b1);
        check("5a_data",  rnd_data, 8'h5A);
        rnd_ready = 1'b1;
        start     = 1'b0;
        @(posedge clk);
        #1;
        rnd_ready = 1'b0;
        check("5a_accept_valid", rnd_valid, 1'b0);
        check("5a_to_idle",      state_o, 3'd0);
        check("5a_ro_off",       ro_enable, 1'b0);
        check("5a_data_kept",    rnd_data, 8'h5A);

        // Table-driven words, each run from IDLE.
        for (int v = 0; v < 4; v++) begin
            debias_en = vecs[v].debias;
            start     = 1'b1;
            wait_state({vecs[v].name, "_collect"}, 1'b0, 3'd2);
            apply_bits(vecs[v].smp >> 1, vecs[v].n - 1);
            check({vecs[v].name, "_early"}, rnd_valid, 1'b0);
            apply_sample(vecs[v].smp[0]);
            check({vecs[v].name, "_valid"}, rnd_valid, 1'b1);
            check({vecs[v].name, "_data"},  rnd_data, vecs[v].word);
            rnd_ready = 1'b1;
            start     = 1'b0;
            @(posedge clk);
            #1;
            rnd_ready = 1'b0;
            check({vecs[v].name, "_idle"}, state_o, 3'd0);
            @(posedge clk);
            #1;
        end

        // Abort after 3 emitted bits, then restart with no stale bits.
        debias_en = 1'b0;
        start     = 1'b1;
        wait_state("abort_collect", 1'b0, 3'd2);
        apply_bits(32'h7, 3);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle",  state_o, 3'd0);
        check("abort_ro",    ro_enable, 1'b0);
        check("abort_valid", rnd_valid, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        wait_state("restart_collect", 1'b0, 3'd2);
        apply_bits(32'h01, 5);
        check("restart_no_stale", rnd_valid, 1'b0);
        apply_bits(32'h7, 3);
        check("restart_valid", rnd_valid, 1'b1);
        check("restart_data",  rnd_data, 8'h0F);
        rnd_ready = 1'b1;
        start     = 1'b0;
        @(posedge clk);
        #1;
        rnd_ready = 1'b0;

        // Health test, REP_LIMIT 4: stuck-at-1 source.
        start_h = 1'b1;
        wait_state("h_collect", 1'b1, 3'd2);
        apply_bits(32'h7, 3);
        check("h_three_ok",    health_fail_h, 1'b0);
        check("h_three_state", state_h, 3'd2);
        apply_sample(1'b1);
        check("h_fail",  health_fail_h, 1'b1);
        check("h_ro",    ro_enable_h, 1'b0);
        check("h_state", state_h, 3'd4);
        check("h_valid", rnd_valid_h, 1'b0);
        start_h = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_h = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("h_sticky",       health_fail_h, 1'b1);
        check("h_sticky_state", state_h, 3'd4);
        start_h = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("h_rst_fail",  health_fail_h, 1'b0);
        check("h_rst_state", state_h, 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Health failure on the strobe that would complete a word: fault wins.
        start_h = 1'b1;
        wait_state("hw_collect", 1'b1, 3'd2);
        apply_bits(32'h57, 7);
        check("hw_pre_state", state_h, 3'd2);
        check("hw_pre_valid", rnd_valid_h, 1'b0);
        apply_sample(1'b1);
        check("hw_state",  state_h, 3'd4);
        check("hw_valid",  rnd_valid_h, 1'b0);
        check("hw_health", health_fail_h, 1'b1);
        check("hw_main_ok", health_fail, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
